bus_reg_bank: RTL and testbench
===============================

# bus_reg_bank

Parametrised register-bank slave on the team's simple `wr`/`rd`/`addr`/`data_i`/`data_o` peripheral bus. It is the next generation of the bare bus slave and adds:
- configurable data width, address width and register count;
- a registered read path with a read-valid strobe;
- an error response for bad accesses;
- per-register read-only mode, where software reads hardware-provided status.

It sits between the bus master and a peripheral's control/status logic.

## Interface
Parameters:
- `DATA_W`, 32, data width in bits (8..64)
- `ADDR_W`, 32, bus address width in bits
- `N_REGS`, 8, number of registers (1..256)
- `BASE_ADDR`, 0, word address of register 0; the bus is word-addressed
- `RO_MASK`, 0 (`N_REGS` bits), bit i = 1 makes register i read-only, sourced from `reg_i`
- `RST_VAL`, 0 (`DATA_W` bits), reset value of every read-write register

Ports. One clock; reset is synchronous and active-high.
- `clk` in 1 system clock
- `rst` in 1 synchronous active-high reset
- `bus_wr` in 1 write request, single-cycle qualifier
- `bus_rd` in 1 read request, single-cycle qualifier
- `bus_addr` in `ADDR_W` word address
- `bus_data_i` in `DATA_W` write data
- `bus_data_o` out `DATA_W` read data, registered
- `bus_rvalid` out 1 one-cycle pulse: `bus_data_o` holds the response to a read
- `bus_err` out 1 one-cycle pulse: the previous cycle's access was rejected
- `reg_o` out `N_REGS*DATA_W` current contents of all registers; slice i = register i
- `reg_i` in `N_REGS*DATA_W` hardware values for read-only registers (slice i)
- `reg_wstb` out `N_REGS` one-cycle pulse per register written successfully

## Operation
Address decode:
- index = `bus_addr - BASE_ADDR`, computed at `ADDR_W` width, unsigned.
- The address is in range iff `bus_addr >= BASE_ADDR` and index < `N_REGS`.
- Wrap-around below `BASE_ADDR` must not alias into range.

Write (`bus_wr`=1):
- In range and not read-only: register[index] <= `bus_data_i` at the next edge, and `reg_wstb[index]` pulses in the following cycle.
- Out of range, or read-only: no state change and `bus_err` pulses.

Read (`bus_rd`=1):
- In range: `bus_data_o` <= register[index], or `reg_i` slice if read-only, sampled in the request cycle. `bus_rvalid` pulses.
- Out of range: `bus_data_o` <= 0, `bus_rvalid` and `bus_err` both pulse.

Simultaneous `bus_wr` and `bus_rd`:
- Both are performed on the same index.
- The read returns the pre-write value (read-before-write).
- `bus_err` pulses if either access is rejected.

Other rules:
- `bus_data_o` holds its value between reads and is only updated by a read.
- Read-only slices of `reg_o` mirror `reg_i` combinationally. Read-write slices come straight from the storage flops.
- State is storage plus the output registers only. Requests are accepted every cycle; there is no backpressure and no FSM beyond a one-stage response pipeline.

## Timing
- Reset values:
  - read-write registers = `RST_VAL`
  - `bus_data_o` = 0
  - `bus_rvalid` = 0, `bus_err` = 0, `reg_wstb` = 0
- Reset mid-operation: a request in the same cycle as `rst`=1 is discarded. No strobe or response follows it.
- Write latency:
  - request in cycle N;
  - `reg_o` and `reg_wstb` show it in cycle N+1.
- Read latency:
  - request in cycle N;
  - `bus_data_o` and `bus_rvalid` valid in cycle N+1;
  - `bus_rvalid` lasts exactly 1 cycle.
- Back-to-back requests every cycle are supported at full throughput. A read in N+1 of a register written in N returns the new value.
- `bus_err` is asserted in cycle N+1 alongside the response it refers to, for both reads and writes.

## Test plan
- Reset, then read all registers with `N_REGS`=8, `RST_VAL`=0xA5A5_0000 -> each `bus_rvalid` pulse carries 0xA5A5_0000; `bus_err`=0 throughout.
- Write 0x1234_5678 to `BASE_ADDR`+3, read it back in the next cycle -> `reg_wstb`=8'b0000_1000 for one cycle; read returns 0x1234_5678 one cycle after `bus_rd`.
- With `RO_MASK`=8'h01 and `reg_i` slice 0 = 0xDEAD_BEEF, write 0 to register 0 then read it -> write gives `bus_err` pulse and no `reg_wstb`; read returns 0xDEAD_BEEF.
- With `BASE_ADDR`=0x100, access 0x108 and 0x0FF:
  - write to either -> `bus_err` pulse, no state change;
  - read of either -> `bus_data_o`=0 with `bus_rvalid` and `bus_err` set.
- Simultaneous `bus_wr`+`bus_rd` to register 2 (old value 0x11, new 0x22) -> read returns 0x11; the following read returns 0x22.
- Assert `rst` in the same cycle as a write to register 5 -> register 5 = `RST_VAL` and no `reg_wstb`, `bus_rvalid` or `bus_err` pulse afterwards.

Source files
------------

// File: rtl/bus_reg_bank.sv
// Parametrised register bank on the simple wr/rd peripheral bus, with registered read data,
// read-valid and error strobes, and per-register read-only status inputs.
module bus_reg_bank #(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       N_REGS    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [N_REGS-1:0] RO_MASK   = '0,
    parameter logic [DATA_W-1:0] RST_VAL   = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bus_wr,
    input  logic                     bus_rd,
    input  logic [ADDR_W-1:0]        bus_addr,
    input  logic [DATA_W-1:0]        bus_data_i,
    output logic [DATA_W-1:0]        bus_data_o,
    output logic                     bus_rvalid,
    output logic                     bus_err,
    output logic [N_REGS*DATA_W-1:0] reg_o,
    input  logic [N_REGS*DATA_W-1:0] reg_i,
    output logic [N_REGS-1:0]        reg_wstb
);

    logic [DATA_W-1:0] r_regs [N_REGS];
    logic [DATA_W-1:0] r_data;
    logic              r_rvalid;
    logic              r_err;
    logic [N_REGS-1:0] r_wstb;

    logic              w_borrow;
    logic [ADDR_W-1:0] w_idx;
    logic [N_REGS-1:0] w_hit;
    logic [N_REGS-1:0] w_we;
    logic              w_in_range;
    logic              w_ro;
    logic              w_wr_err;
    logic              w_rd_err;
    logic [DATA_W-1:0] w_rd_data;
    logic              w_unused_reg_i;

    // The borrow flags addresses below BASE_ADDR so a wrapped index never aliases into range.
    assign {w_borrow, w_idx} = {1'b0, bus_addr} - {1'b0, BASE_ADDR};

    always_comb begin
        w_hit = '0;
        for (int i = 0; i < int'(N_REGS); i++) begin
            w_hit[i] = !w_borrow && (w_idx == ADDR_W'(i));
        end
    end

    assign w_in_range = |w_hit;
    assign w_ro       = |(w_hit & RO_MASK);
    assign w_we       = w_hit & ~RO_MASK & {N_REGS{bus_wr}};
    assign w_wr_err   = bus_wr && (!w_in_range || w_ro);
    assign w_rd_err   = bus_rd && !w_in_range;

    always_comb begin
        reg_o = '0;
        for (int i = 0; i < int'(N_REGS); i++) begin
            reg_o[i*DATA_W +: DATA_W] = RO_MASK[i] ? reg_i[i*DATA_W +: DATA_W] : r_regs[i];
        end
    end

    // Reads see storage before any same-cycle write lands, giving read-before-write.
    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < int'(N_REGS); i++) begin
            if (w_hit[i]) begin
                w_rd_data = reg_o[i*DATA_W +: DATA_W];
            end
        end
    end

    // Slices of reg_i belonging to read-write registers are ignored.
    assign w_unused_reg_i = ^reg_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(N_REGS); i++) begin
                r_regs[i] <= RST_VAL;
            end
            r_data   <= '0;
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_wstb   <= '0;
        end else begin
            for (int i = 0; i < int'(N_REGS); i++) begin
                if (w_we[i]) begin
                    r_regs[i] <= bus_data_i;
                end
            end
            if (bus_rd) begin
                r_data <= w_rd_data;
            end
            r_rvalid <= bus_rd;
            r_err    <= w_wr_err || w_rd_err;
            r_wstb   <= w_we;
        end
    end

    assign bus_data_o = r_data;
    assign bus_rvalid = r_rvalid;
    assign bus_err    = r_err;
    assign reg_wstb   = r_wstb;

endmodule

// File: tb/tb_bus_reg_bank.sv
// Scoreboard bench for bus_reg_bank: BASE_ADDR=0x100, register 0 read-only, RST_VAL=0xA5A5_0000.
module tb_bus_reg_bank;

    localparam logic [31:0] Base   = 32'h0000_0100;
    localparam logic [7:0]  RoMask = 8'h01;
    localparam logic [31:0] RstVal = 32'hA5A5_0000;

    typedef struct {
        logic        rvalid;
        logic        err;
        logic [31:0] data;
        logic [7:0]  wstb;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         bus_wr = 1'b0;
    logic         bus_rd = 1'b0;
    logic [31:0]  bus_addr = '0;
    logic [31:0]  bus_data_i = '0;
    logic [31:0]  bus_data_o;
    logic         bus_rvalid;
    logic         bus_err;
    logic [255:0] reg_o;
    logic [255:0] reg_i;
    logic [7:0]   reg_wstb;

    exp_t        q[$];
    logic [31:0] m_regs [8];
    logic [31:0] m_dout;
    int          n_vec = 0;
    int          n_err = 0;

    bus_reg_bank #(
        .DATA_W   (32),
        .ADDR_W   (32),
        .N_REGS   (8),
        .BASE_ADDR(Base),
        .RO_MASK  (RoMask),
        .RST_VAL  (RstVal)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .bus_wr    (bus_wr),
        .bus_rd    (bus_rd),
        .bus_addr  (bus_addr),
        .bus_data_i(bus_data_i),
        .bus_data_o(bus_data_o),
        .bus_rvalid(bus_rvalid),
        .bus_err   (bus_err),
        .reg_o     (reg_o),
        .reg_i     (reg_i),
        .reg_wstb  (reg_wstb)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] model_reg_o();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) begin
            v[i*32 +: 32] = RoMask[i] ? reg_i[i*32 +: 32] : m_regs[i];
        end
        return v;
    endfunction

    // Drive one request cycle, push its expected response, then step to just after the edge.
    task automatic issue(input logic wr, input logic rd, input logic [31:0] addr,
                         input logic [31:0] data);
        exp_t        e;
        logic [31:0] idx;
        logic        in_r;
        logic        ro;
        @(negedge clk);
        bus_wr = wr;
        bus_rd = rd;
        bus_addr = addr;
        bus_data_i = data;
        idx  = addr - Base;
        in_r = (addr >= Base) && (idx < 32'd8);
        ro   = in_r && RoMask[idx[2:0]];
        if (rd) m_dout = !in_r ? 32'h0 : (ro ? reg_i[idx[2:0]*32 +: 32] : m_regs[idx[2:0]]);
        e.rvalid = rd;
        e.err    = (rd && !in_r) || (wr && (!in_r || ro));
        e.data   = m_dout;
        e.wstb   = '0;
        if (wr && in_r && !ro) begin
            m_regs[idx[2:0]] = data;
            e.wstb[idx[2:0]] = 1'b1;
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        bus_wr = 1'b0;
        bus_rd = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) m_regs[i] = RstVal;
        m_dout = '0;
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({bus_rvalid, bus_err, reg_wstb, bus_data_o} !== 42'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got rv=%b err=%b wstb=%h data=%h want all zero",
                     bus_rvalid, bus_err, reg_wstb, bus_data_o);
        end
        n_vec++;
        if (reg_o !== model_reg_o()) begin
            n_err++;
            $display("FAIL reset_reg_o: got %h want %h", reg_o, model_reg_o());
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_read_all();
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            issue(1'b0, 1'b1, Base + i, 32'h0);
            e = q.pop_front();
            n_vec++;
            if (bus_rvalid !== 1'b1 || bus_err !== 1'b0 || bus_data_o !== e.data) begin
                n_err++;
                $display("FAIL read_all[%0d]: got rv=%b err=%b data=%h want rv=1 err=0 data=%h",
                         i, bus_rvalid, bus_err, bus_data_o, e.data);
            end
        end
    endtask

    task automatic test_write_readback();
        exp_t e;
        issue(1'b1, 1'b0, Base + 3, 32'h1234_5678);
        e = q.pop_front();
        n_vec++;
        if (reg_wstb !== 8'b0000_1000 || bus_err !== e.err || bus_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL wr3_strobe: got wstb=%b err=%b rv=%b want wstb=00001000 err=0 rv=0",
                     reg_wstb, bus_err, bus_rvalid);
        end
        n_vec++;
        if (reg_o[3*32 +: 32] !== 32'h1234_5678) begin
            n_err++;
            $display("FAIL wr3_reg_o: got %h want 12345678", reg_o[3*32 +: 32]);
        end
        issue(1'b0, 1'b1, Base + 3, 32'h0);
        e = q.pop_front();
        n_vec++;
        if (bus_data_o !== 32'h1234_5678 || bus_rvalid !== 1'b1 || reg_wstb !== e.wstb) begin
            n_err++;
            $display("FAIL rd3: got data=%h rv=%b wstb=%b want data=12345678 rv=1 wstb=%b",
                     bus_data_o, bus_rvalid, reg_wstb, e.wstb);
        end
    endtask

    task automatic test_read_only();
        exp_t e;
        issue(1'b1, 1'b0, Base, 32'h0);
        e = q.pop_front();
        n_vec++;
        if (bus_err !== 1'b1 || reg_wstb !== 8'h00 || reg_o !== model_reg_o()) begin
            n_err++;
            $display("FAIL ro_write: got err=%b wstb=%b want err=1 wstb=0 regs unchanged",
                     bus_err, reg_wstb);
        end
        issue(1'b0, 1'b1, Base, 32'h0);
        e = q.pop_front();
        n_vec++;
        if (bus_data_o !== 32'hDEAD_BEEF || bus_rvalid !== 1'b1 || bus_err !== e.err) begin
            n_err++;
            $display("FAIL ro_read: got data=%h rv=%b err=%b want data=deadbeef rv=1 err=0",
                     bus_data_o, bus_rvalid, bus_err);
        end
        reg_i[31:0] = 32'h0BAD_F00D;
        #1;
        n_vec++;
        if (reg_o[31:0] !== 32'h0BAD_F00D) begin
            n_err++;
            $display("FAIL ro_mirror: got %h want 0badf00d", reg_o[31:0]);
        end
        reg_i[31:0] = 32'hDEAD_BEEF;
    endtask

    task automatic test_out_of_range();
        exp_t        e;
        logic [31:0] addrs [3];
        addrs[0] = 32'h0000_0108;
        addrs[1] = 32'h0000_00FF;
        addrs[2] = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            issue(1'b1, 1'b0, addrs[i], 32'hFFFF_FFFF);
            e = q.pop_front();
            n_vec++;
            if (bus_err !== 1'b1 || reg_wstb !== 8'h00 || reg_o !== model_reg_o()) begin
                n_err++;
                $display("FAIL oor_write[%h]: got err=%b wstb=%b reg_o=%h want err=1 wstb=0 %h",
                         addrs[i], bus_err, reg_wstb, reg_o, model_reg_o());
            end
            // Load a non-zero value first so the zeroed error response is visible.
            issue(1'b0, 1'b1, Base + 3, 32'h0);
            e = q.pop_front();
            issue(1'b0, 1'b1, addrs[i], 32'h0);
            e = q.pop_front();
            n_vec++;
            if (bus_data_o !== 32'h0 || bus_rvalid !== 1'b1 || bus_err !== 1'b1) begin
                n_err++;
                $display("FAIL oor_read[%h]: got data=%h rv=%b err=%b want data=0 rv=1 err=1",
                         addrs[i], bus_data_o, bus_rvalid, bus_err);
            end
        end
    endtask

    task automatic test_rw_same();
        exp_t e;
        issue(1'b1, 1'b0, Base + 2, 32'h11);
        e = q.pop_front();
        issue(1'b1, 1'b1, Base + 2, 32'h22);
        e = q.pop_front();
        n_vec++;
        if (bus_data_o !== 32'h11 || bus_rvalid !== 1'b1 || reg_wstb !== 8'b0000_0100
            || bus_err !== e.err) begin
            n_err++;
            $display("FAIL rw_same: got data=%h rv=%b wstb=%b err=%b want data=11 rv=1 wstb=100",
                     bus_data_o, bus_rvalid, reg_wstb, bus_err);
        end
        issue(1'b0, 1'b0, 32'h0, 32'h0);
        e = q.pop_front();
        n_vec++;
        if (bus_data_o !== 32'h11 || bus_rvalid !== 1'b0 || bus_err !== 1'b0) begin
            n_err++;
            $display("FAIL data_hold: got data=%h rv=%b err=%b want data=11 rv=0 err=0",
                     bus_data_o, bus_rvalid, bus_err);
        end
        issue(1'b0, 1'b1, Base + 2, 32'h0);
        e = q.pop_front();
        n_vec++;
        if (bus_data_o !== 32'h22 || bus_rvalid !== 1'b1) begin
            n_err++;
            $display("FAIL rw_after: got data=%h rv=%b want data=22 rv=1", bus_data_o, bus_rvalid);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 1; i < 8; i++) begin
            issue(1'b1, 1'b0, Base + i, 32'h5A00_0000 | $urandom_range(0, 32'hFFFF));
            e = q.pop_front();
            n_vec++;
            if (reg_wstb !== e.wstb || bus_err !== e.err) begin
                n_err++;
                $display("FAIL b2b_wr[%0d]: got wstb=%b err=%b want wstb=%b err=%b",
                         i, reg_wstb, bus_err, e.wstb, e.err);
            end
            issue(1'b0, 1'b1, Base + i, 32'h0);
            e = q.pop_front();
            n_vec++;
            if (bus_data_o !== e.data || bus_rvalid !== 1'b1 || reg_wstb !== 8'h00) begin
                n_err++;
                $display("FAIL b2b_rd[%0d]: got data=%h rv=%b wstb=%b want data=%h rv=1 wstb=0",
                         i, bus_data_o, bus_rvalid, reg_wstb, e.data);
            end
        end
        n_vec++;
        if (reg_o !== model_reg_o()) begin
            n_err++;
            $display("FAIL b2b_reg_o: got %h want %h", reg_o, model_reg_o());
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        issue(1'b1, 1'b0, Base + 5, 32'h0000_5555);
        e = q.pop_front();
        @(negedge clk);
        rst = 1'b1;
        bus_wr = 1'b1;
        bus_rd = 1'b1;
        bus_addr = Base + 5;
        bus_data_i = 32'hCAFE_CAFE;
        for (int i = 0; i < 8; i++) m_regs[i] = RstVal;
        m_dout = '0;
        @(posedge clk);
        #1;
        bus_wr = 1'b0;
        bus_rd = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if (reg_o[5*32 +: 32] !== RstVal || reg_o !== model_reg_o()) begin
            n_err++;
            $display("FAIL rst_mid_reg5: got %h want %h", reg_o[5*32 +: 32], RstVal);
        end
        issue(1'b0, 1'b0, 32'h0, 32'h0);
        e = q.pop_front();
        n_vec++;
        if (reg_wstb !== 8'h00 || bus_rvalid !== 1'b0 || bus_err !== 1'b0
            || bus_data_o !== 32'h0) begin
            n_err++;
            $display("FAIL rst_mid_pulse: got wstb=%b rv=%b err=%b data=%h want all zero",
                     reg_wstb, bus_rvalid, bus_err, bus_data_o);
        end
    endtask

    initial begin
        reg_i = '0;
        for (int i = 0; i < 8; i++) reg_i[i*32 +: 32] = 32'h5000_0000 + i;
        reg_i[31:0] = 32'hDEAD_BEEF;
        m_dout = '0;
        test_reset();
        test_read_all();
        test_write_readback();
        test_read_only();
        test_out_of_range();
        test_rw_same();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
